// File: rtl/saber_pkg.sv
// Shared types and constants for the saber renderer slice: animation state
// encoding, Q8 unit, datapath widths and the flicker LFSR constants.
package saber_pkg;

   typedef enum logic [1:0] {
      OFF        = 2'd0,
      EXTENDING  = 2'd1,
      LIT        = 2'd2,
      RETRACTING = 2'd3
   } saber_state_e;

   localparam int Q8_ONE  = 256;
   localparam int COORD_W = 12;
   localparam int PROD_W  = 26;

   // Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef logic signed [COORD_W-1:0] coord_t;
   typedef logic signed [PROD_W-1:0]  prod_t;

   // Blade vector and the per-frame constants derived from it
   typedef struct packed {
      coord_t               dx;
      coord_t               dy;
      logic [23:0]          dd;
      logic [COORD_W-1:0]   dm;
   } geo_t;

   // Magnitude of a signed coordinate; -2048 maps to 2048 as unsigned
   function automatic logic [COORD_W-1:0] abs_c(input coord_t v);
      return (v < 0) ? COORD_W'(-v) : COORD_W'(v);
   endfunction

endpackage

// File: rtl/saber_renderer_if.sv
// Tracker/mux facing bundle of the saber renderer. The master side (handle
// tracker plus video timing) drives geometry and pixel stream; the renderer
// (slave) returns the rendered pixel and status.
interface saber_renderer_if;
   logic        frame_start;
   logic        on;
   logic [10:0] handle_top_x;
   logic [9:0]  handle_top_y;
   logic [10:0] handle_bottom_x;
   logic [9:0]  handle_bottom_y;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [23:0] color;
   logic [23:0] background;
   logic [23:0] pixel;
   logic        occupied;
   logic        lit;

   modport master (
      output frame_start, on,
      output handle_top_x, handle_top_y, handle_bottom_x, handle_bottom_y,
      output hcount, vcount, color, background,
      input  pixel, occupied, lit
   );

   modport slave (
      input  frame_start, on,
      input  handle_top_x, handle_top_y, handle_bottom_x, handle_bottom_y,
      input  hcount, vcount, color, background,
      output pixel, occupied, lit
   );
endinterface

// File: rtl/alpha_blend.sv
// Fixed 50% glow blend: each 8-bit channel is the floor average of the blade
// colour and the background.
module alpha_blend (
   input  logic [23:0] fg,
   input  logic [23:0] bg,
   output logic [23:0] mix
);

   logic [8:0] sum;

   // Per-channel average, computed with a 9-bit sum so no carry is lost
   always_comb begin
      mix = '0;
      sum = '0;
      for (int i = 0; i < 3; i++) begin
         sum = {1'b0, fg[8*i +: 8]} + {1'b0, bg[8*i +: 8]};
         mix[8*i +: 8] = sum[8:1];
      end
   end

endmodule

// File: rtl/saber_ignite_ctrl.sv
// Ignition / retraction animation. ext is a Q8 blade extension (0..256) that
// moves by one step per frame_start in the direction selected by 'on'.
module saber_ignite_ctrl
   import saber_pkg::*;
#(
   parameter int IGNITE_STEP  = 32,
   parameter int RETRACT_STEP = 64
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       frame_start,
   input  logic       on,
   output logic [8:0] ext,
   output logic       lit
);

   saber_state_e state, state_n;
   logic [8:0]   ext_n;
   logic [9:0]   up_sum;

   // State and extension registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= OFF;
         ext   <= '0;
      end else begin
         state <= state_n;
         ext   <= ext_n;
      end
   end

   // Step ext toward 256 or 0 on each frame pulse, saturating at the ends;
   // direction follows 'on' at pulse time so a reversal never jumps
   always_comb begin
      state_n = state;
      ext_n   = ext;
      up_sum  = {1'b0, ext} + 10'(IGNITE_STEP);
      if (frame_start) begin
         if (on && ext < 9'(Q8_ONE)) begin
            if (up_sum >= 10'(Q8_ONE)) begin
               ext_n   = 9'(Q8_ONE);
               state_n = LIT;
            end else begin
               ext_n   = up_sum[8:0];
               state_n = EXTENDING;
            end
         end else if (!on && ext != 9'd0) begin
            if (ext <= 9'(RETRACT_STEP)) begin
               ext_n   = '0;
               state_n = OFF;
            end else begin
               ext_n   = ext - 9'(RETRACT_STEP);
               state_n = RETRACTING;
            end
         end
      end
   end

   assign lit = (state == LIT);

endmodule

// File: rtl/saber_renderer.sv
// Lightsaber blade renderer: solid core plus blended glow around the segment
// from the top handle point along BLADE_LENGTH-1 handle lengths, scaled by the
// animation extension. Geometry is latched once per frame; pixels flow through
// a fixed 3-stage pipeline. Define SABER_FLICKER_EN for LFSR glow flicker.
module saber_renderer
   import saber_pkg::*;
#(
   parameter int BLADE_LENGTH = 3,
   parameter int CORE_W       = 3,
   parameter int GLOW_W       = 8,
   parameter int IGNITE_STEP  = 32,
   parameter int RETRACT_STEP = 64
) (
   input  logic         clock,
   input  logic         reset_n,
   saber_renderer_if.slave sb
);

   localparam logic [PROD_W-1:0] CORE_K = PROD_W'(CORE_W);

   logic [8:0]  ext;
   logic        lit;
   logic        geo_upd;
   coord_t      bx, by, hx, hy;
   geo_t        geo, geo_n;
   logic signed [31:0] ext_s, dx_full, dy_full;
   logic signed [23:0] dx_sq, dy_sq;
   logic [COORD_W-1:0] adx, ady;

   coord_t      vx1, vy1;
   logic [23:0] bg1, bg2;
   prod_t       cross2, along2;
   logic [PROD_W-1:0] abs_cross, dm_w, core_thr, glow_thr;
   logic        span_out;
   logic [23:0] blend_rgb;
   logic [23:0] pixel_q;
   logic        occ_q;

   saber_ignite_ctrl #(
      .IGNITE_STEP  (IGNITE_STEP),
      .RETRACT_STEP (RETRACT_STEP)
   ) u_ctrl (
      .clock       (clock),
      .reset_n     (reset_n),
      .frame_start (sb.frame_start),
      .on          (sb.on),
      .ext         (ext),
      .lit         (lit)
   );

   // Latch handle base and handle vector at the frame pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bx      <= '0;
         by      <= '0;
         hx      <= '0;
         hy      <= '0;
         geo_upd <= 1'b0;
      end else begin
         geo_upd <= sb.frame_start;
         if (sb.frame_start) begin
            bx <= coord_t'({1'b0, sb.handle_top_x});
            by <= coord_t'({2'b0, sb.handle_top_y});
            hx <= coord_t'({1'b0, sb.handle_top_x}) - coord_t'({1'b0, sb.handle_bottom_x});
            hy <= coord_t'({2'b0, sb.handle_top_y}) - coord_t'({2'b0, sb.handle_bottom_y});
         end
      end
   end

   // Blade vector scaled by the freshly stepped extension, plus its squared
   // length and Chebyshev length used as segment-test references
   always_comb begin
      ext_s    = $signed({23'd0, ext});
      dx_full  = 32'(hx) * ext_s * (BLADE_LENGTH - 1);
      dy_full  = 32'(hy) * ext_s * (BLADE_LENGTH - 1);
      geo_n    = '0;
      geo_n.dx = coord_t'(dx_full >>> 8);
      geo_n.dy = coord_t'(dy_full >>> 8);
      dx_sq    = 24'(geo_n.dx) * 24'(geo_n.dx);
      dy_sq    = 24'(geo_n.dy) * 24'(geo_n.dy);
      geo_n.dd = $unsigned(dx_sq) + $unsigned(dy_sq);
      adx      = abs_c(geo_n.dx);
      ady      = abs_c(geo_n.dy);
      geo_n.dm = (adx > ady) ? adx : ady;
   end

   // Geometry register, loaded the cycle after the pulse (ext is valid then)
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)     geo <= '0;
      else if (geo_upd) geo <= geo_n;
   end

   // S1: pixel relative to blade base; S2: cross and along products
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vx1    <= '0;
         vy1    <= '0;
         bg1    <= '0;
         cross2 <= '0;
         along2 <= '0;
         bg2    <= '0;
      end else begin
         vx1    <= coord_t'({1'b0, sb.hcount}) - bx;
         vy1    <= coord_t'({2'b0, sb.vcount}) - by;
         bg1    <= sb.background;
         cross2 <= prod_t'(vx1) * prod_t'(geo.dy) - prod_t'(vy1) * prod_t'(geo.dx);
         along2 <= prod_t'(vx1) * prod_t'(geo.dx) + prod_t'(vy1) * prod_t'(geo.dy);
         bg2    <= bg1;
      end
   end

`ifdef SABER_FLICKER_EN
   logic [15:0] lfsr;

   // Glow-edge jitter source, stepped once per frame
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)            lfsr <= LFSR_SEED;
      else if (sb.frame_start) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
   end

   // Glow multiplier varies in GLOW_W-1 .. GLOW_W+2
   always_comb begin
      dm_w     = PROD_W'(geo.dm);
      glow_thr = (PROD_W'(GLOW_W - 1) + PROD_W'(lfsr[1:0])) * dm_w;
   end
`else
   // Fixed glow radius
   always_comb begin
      dm_w     = PROD_W'(geo.dm);
      glow_thr = PROD_W'(GLOW_W) * dm_w;
   end
`endif

   // S3 classification inputs: distance proxy and segment span test
   always_comb begin
      abs_cross = (cross2 < 0) ? PROD_W'(-cross2) : PROD_W'(cross2);
      core_thr  = CORE_K * dm_w;
      span_out  = (ext == 9'd0) || (along2 < 0) || (along2 > $signed({2'b0, geo.dd}));
   end

   alpha_blend u_blend (
      .fg  (sb.color),
      .bg  (bg2),
      .mix (blend_rgb)
   );

   // S3 output register: off-segment, core, glow, or empty in priority order
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pixel_q <= '0;
         occ_q   <= 1'b0;
      end else if (span_out) begin
         pixel_q <= '0;
         occ_q   <= 1'b0;
      end else if (abs_cross < core_thr) begin
         pixel_q <= sb.color;
         occ_q   <= 1'b1;
      end else if (abs_cross < glow_thr) begin
         pixel_q <= blend_rgb;
         occ_q   <= 1'b1;
      end else begin
         pixel_q <= '0;
         occ_q   <= 1'b0;
      end
   end

   assign sb.pixel    = pixel_q;
   assign sb.occupied = occ_q;
   assign sb.lit      = lit;

endmodule

// File: tb/tb_saber_renderer.sv
// Directed bench for saber_renderer with the default parameters.
module tb_saber_renderer;
   import saber_pkg::*;

   localparam logic [23:0] COLOR = 24'hFF2010;
   localparam logic [23:0] BG    = 24'h0040F0;
   localparam logic [23:0] BLEND = 24'h7F3080;

   logic clock = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   saber_renderer_if sb();

   saber_renderer dut (
      .clock   (clock),
      .reset_n (reset_n),
      .sb      (sb)
   );

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic set_handles(input int tx, input int ty, input int bx, input int by);
      sb.handle_top_x    = 11'(tx);
      sb.handle_top_y    = 10'(ty);
      sb.handle_bottom_x = 11'(bx);
      sb.handle_bottom_y = 10'(by);
   endtask

   // One frame pulse, then let the geometry register settle
   task automatic pulse();
      sb.frame_start = 1'b1;
      cyc();
      sb.frame_start = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic render(input int x, input int y, output logic [23:0] p, output logic o);
      sb.hcount = 11'(x);
      sb.vcount = 10'(y);
      repeat (3) cyc();
      p = sb.pixel;
      o = sb.occupied;
   endtask

   task automatic test_reset();
      sb.frame_start = 1'b0;
      sb.on          = 1'b0;
      set_handles(400, 300, 400, 340);
      sb.hcount      = '0;
      sb.vcount      = '0;
      sb.color       = COLOR;
      sb.background  = BG;
      reset_n        = 1'b0;
      cyc();
      cyc();
      checks++; if (sb.pixel !== 24'h0) begin errors++; $display("FAIL reset_pixel: got %h expected 000000", sb.pixel); end
      checks++; if (sb.occupied !== 1'b0) begin errors++; $display("FAIL reset_occupied: got %b expected 0", sb.occupied); end
      checks++; if (sb.lit !== 1'b0) begin errors++; $display("FAIL reset_lit: got %b expected 0", sb.lit); end
      checks++; if (dut.u_ctrl.ext !== 9'd0) begin errors++; $display("FAIL reset_ext: got %0d expected 0", dut.u_ctrl.ext); end
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_ignite();
      logic [23:0] p;
      logic        o;
      sb.on = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         pulse();
         checks++;
         if (dut.u_ctrl.ext !== 9'(32 * k)) begin
            errors++; $display("FAIL ignite_ext_%0d: got %0d expected %0d", k, dut.u_ctrl.ext, 32 * k);
         end
         if (k == 4) begin
            render(400, 270, p, o);
            checks++; if (o !== 1'b1 || p !== COLOR) begin errors++; $display("FAIL half_core: got occ=%b pix=%h expected occ=1 pix=%h", o, p, COLOR); end
            render(400, 250, p, o);
            checks++; if (o !== 1'b0 || p !== 24'h0) begin errors++; $display("FAIL half_beyond: got occ=%b pix=%h expected occ=0 pix=000000", o, p); end
         end
         if (k == 7) begin
            checks++; if (sb.lit !== 1'b0) begin errors++; $display("FAIL lit_early: got %b expected 0", sb.lit); end
         end
      end
      checks++; if (sb.lit !== 1'b1) begin errors++; $display("FAIL lit_full: got %b expected 1", sb.lit); end
   endtask

   task automatic test_latency();
      sb.hcount = '0;
      sb.vcount = '0;
      repeat (3) cyc();
      sb.hcount = 11'd402;
      sb.vcount = 10'd260;
      cyc();
      checks++; if (sb.occupied !== 1'b0) begin errors++; $display("FAIL lat_edge1: got %b expected 0", sb.occupied); end
      sb.hcount = '0;
      sb.vcount = '0;
      cyc();
      checks++; if (sb.occupied !== 1'b0) begin errors++; $display("FAIL lat_edge2: got %b expected 0", sb.occupied); end
      cyc();
      checks++; if (sb.occupied !== 1'b1 || sb.pixel !== COLOR) begin errors++; $display("FAIL lat_edge3: got occ=%b pix=%h expected occ=1 pix=%h", sb.occupied, sb.pixel, COLOR); end
      cyc();
      checks++; if (sb.occupied !== 1'b0) begin errors++; $display("FAIL lat_edge4: got %b expected 0", sb.occupied); end
   endtask

   task automatic test_segment();
      int          xs [5] = '{402, 405, 410, 400, 400};
      int          ys [5] = '{260, 260, 260, 210, 305};
      logic        eo [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [23:0] ep [5] = '{COLOR, BLEND, 24'h0, 24'h0, 24'h0};
      logic [23:0] p;
      logic        o;
      for (int i = 0; i < 5; i++) begin
         render(xs[i], ys[i], p, o);
         checks++;
         if (o !== eo[i] || p !== ep[i]) begin
            errors++; $display("FAIL seg_%0d_%0d: got occ=%b pix=%h expected occ=%b pix=%h", xs[i], ys[i], o, p, eo[i], ep[i]);
         end
      end
   endtask

   task automatic test_midframe_handles();
      logic [23:0] p;
      logic        o;
      set_handles(600, 100, 600, 140);
      render(402, 260, p, o);
      checks++; if (o !== 1'b1 || p !== COLOR) begin errors++; $display("FAIL midframe_hold: got occ=%b pix=%h expected occ=1 pix=%h", o, p, COLOR); end
      set_handles(400, 300, 400, 340);
   endtask

   task automatic test_degenerate();
      logic [23:0] p;
      logic        o;
      set_handles(400, 300, 400, 300);
      pulse();
      render(400, 300, p, o);
      checks++; if (o !== 1'b0) begin errors++; $display("FAIL degen_base: got %b expected 0", o); end
      render(402, 260, p, o);
      checks++; if (o !== 1'b0) begin errors++; $display("FAIL degen_off: got %b expected 0", o); end
      set_handles(400, 300, 400, 340);
      pulse();
      render(402, 260, p, o);
      checks++; if (o !== 1'b1 || p !== COLOR) begin errors++; $display("FAIL degen_restore: got occ=%b pix=%h expected occ=1 pix=%h", o, p, COLOR); end
   endtask

   task automatic test_reverse();
      sb.on = 1'b0;
      pulse();
      checks++; if (dut.u_ctrl.ext !== 9'd192) begin errors++; $display("FAIL retract_1: got %0d expected 192", dut.u_ctrl.ext); end
      checks++; if (dut.u_ctrl.state !== RETRACTING || sb.lit !== 1'b0) begin errors++; $display("FAIL retract_state: got state=%0d lit=%b expected state=3 lit=0", dut.u_ctrl.state, sb.lit); end
      pulse();
      checks++; if (dut.u_ctrl.ext !== 9'd128) begin errors++; $display("FAIL retract_2: got %0d expected 128", dut.u_ctrl.ext); end
      sb.on = 1'b1;
      pulse();
      checks++; if (dut.u_ctrl.ext !== 9'd160) begin errors++; $display("FAIL reverse_ext: got %0d expected 160", dut.u_ctrl.ext); end
      checks++; if (dut.u_ctrl.state !== EXTENDING) begin errors++; $display("FAIL reverse_state: got %0d expected 1", dut.u_ctrl.state); end
   endtask

   task automatic test_async_reset();
      logic [23:0] p;
      logic        o;
      render(402, 260, p, o);
      checks++; if (o !== 1'b1 || p !== COLOR) begin errors++; $display("FAIL pre_reset_core: got occ=%b pix=%h expected occ=1 pix=%h", o, p, COLOR); end
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (sb.pixel !== 24'h0) begin errors++; $display("FAIL async_pixel: got %h expected 000000", sb.pixel); end
      checks++; if (sb.occupied !== 1'b0) begin errors++; $display("FAIL async_occupied: got %b expected 0", sb.occupied); end
      checks++; if (sb.lit !== 1'b0) begin errors++; $display("FAIL async_lit: got %b expected 0", sb.lit); end
      checks++; if (dut.u_ctrl.ext !== 9'd0 || dut.u_ctrl.state !== OFF) begin errors++; $display("FAIL async_ext: got ext=%0d state=%0d expected 0/0", dut.u_ctrl.ext, dut.u_ctrl.state); end
      @(negedge clock);
      reset_n = 1'b1;
      cyc();
      pulse();
      checks++; if (dut.u_ctrl.ext !== 9'd32) begin errors++; $display("FAIL restart_ext: got %0d expected 32", dut.u_ctrl.ext); end
   endtask

   initial begin
      test_reset();
      test_ignite();
      test_latency();
      test_segment();
      test_midframe_handles();
      test_degenerate();
      test_reverse();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
